// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default sizes and width helpers shared by the FIFO files.
package sync_fifo_pkg;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_DATA_WIDTH = 4;
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_core_if.sv
// sync_fifo_core_if: producer/consumer handshake bundle; FIFO_ERR_FLAGS_EN adds overflow/underflow.
interface sync_fifo_core_if #(parameter int DATA_WIDTH = sync_fifo_pkg::DEF_DATA_WIDTH);
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_val;
  logic                  wr_ready;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
  modport master (output rd_en, wr_en, wr_data, input rd_data, rd_val, wr_ready, overflow, underflow);
  modport slave (input rd_en, wr_en, wr_data, output rd_data, rd_val, wr_ready, overflow, underflow);
`else
  modport master (output rd_en, wr_en, wr_data, input rd_data, rd_val, wr_ready);
  modport slave (input rd_en, wr_en, wr_data, output rd_data, rd_val, wr_ready);
`endif
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: FIFO_DEPTH x DATA_WIDTH register array, one write port and one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int AW = ptr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO with registered read data/valid.
// Optional sticky overflow/underflow flags when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_core_if.slave  bus
);
  localparam int AW = ptr_width(FIFO_DEPTH);
  localparam int CW = cnt_width(FIFO_DEPTH);
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, mem_rdata;
  logic                  rd_val_q, rd_val_d;
  logic                  full, empty, wr_acc, rd_acc;
  sync_fifo_mem #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );
  always_comb begin
    full      = count_q == CW'(FIFO_DEPTH);
    empty     = count_q == '0;
    wr_acc    = bus.wr_en && !full;
    rd_acc    = bus.rd_en && !empty;
    wr_ptr_d  = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);
    rd_val_d  = rd_acc;
    rd_data_d = rd_acc ? mem_rdata : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_val_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_val_q  <= rd_val_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign bus.wr_ready = !full;
  assign bus.rd_val   = rd_val_q;
  assign bus.rd_data  = rd_data_q;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  always_comb begin
    overflow_d  = overflow_q || (bus.wr_en && full);
    underflow_d = underflow_q || (bus.rd_en && empty);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: table-driven directed check of sync_fifo_core plus a mid-operation reset sequence.
module tb_sync_fifo_core;
  typedef struct {
    int rd;
    int wr;
    int d;
    int val;
    int data;
    int rdy;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  sync_fifo_core_if #(.DATA_WIDTH(4)) bus ();
  sync_fifo_core #(.FIFO_DEPTH(4), .DATA_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic add(input int rd, input int wr, input int d, input int val, input int data, input int rdy);
    vecs.push_back('{rd, wr, d, val, data, rdy});
  endtask
  task automatic step(input int rd, input int wr, input int d);
    bus.rd_en   = rd[0];
    bus.wr_en   = wr[0];
    bus.wr_data = 4'(d);
    @(posedge clk);
    #1;
  endtask
  task automatic check_outs(input string tag, input int val, input int data, input int rdy);
    check({tag, " rd_val"}, int'(bus.rd_val), val);
    check({tag, " rd_data"}, int'(bus.rd_data), data);
    check({tag, " wr_ready"}, int'(bus.wr_ready), rdy);
  endtask
  initial begin
    // rd, wr, wr_data, exp rd_val, exp rd_data, exp wr_ready
    add(1, 0, 0, 0, 0, 1);
    add(0, 1, 6, 0, 0, 1);
    add(0, 1, 8, 0, 0, 1);
    add(0, 1, 4, 0, 0, 1);
    add(0, 1, 10, 0, 0, 0);
    add(0, 1, 12, 0, 0, 0);
    add(1, 0, 0, 1, 6, 1);
    add(1, 0, 0, 1, 8, 1);
    add(1, 0, 0, 1, 4, 1);
    add(1, 0, 0, 1, 10, 1);
    add(1, 0, 0, 0, 10, 1);
    add(0, 1, 1, 0, 10, 1);
    add(0, 1, 2, 0, 10, 1);
    add(0, 1, 3, 0, 10, 1);
    add(1, 0, 0, 1, 1, 1);
    add(1, 1, 5, 1, 2, 1);
    add(1, 1, 6, 1, 3, 1);
    add(1, 1, 7, 1, 5, 1);
    add(1, 1, 8, 1, 6, 1);
    add(1, 0, 0, 1, 7, 1);
    add(1, 0, 0, 1, 8, 1);
    add(1, 0, 0, 0, 8, 1);
    add(1, 1, 9, 0, 8, 1);
    add(1, 0, 0, 1, 9, 1);
    add(0, 1, 1, 0, 9, 1);
    add(0, 1, 2, 0, 9, 1);
    add(0, 1, 3, 0, 9, 1);
    add(0, 1, 4, 0, 9, 0);
    add(1, 1, 15, 1, 1, 1);
    add(1, 0, 0, 1, 2, 1);
    add(1, 0, 0, 1, 3, 1);
    add(1, 0, 0, 1, 4, 1);
    add(1, 0, 0, 0, 4, 1);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    check_outs("reset", 0, 0, 1);
    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].d);
      check_outs($sformatf("vec%0d", i), vecs[i].val, vecs[i].data, vecs[i].rdy);
    end
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow sticky", int'(bus.overflow), 1);
    check("underflow sticky", int'(bus.underflow), 1);
`endif
    step(0, 1, 11);
    step(0, 1, 12);
    step(0, 1, 13);
    step(1, 0, 0);
    check_outs("pre-reset read", 1, 11, 1);
    reset = 1'b1;
    step(1, 1, 14);
    reset = 1'b0;
    check_outs("mid reset", 0, 0, 1);
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow cleared", int'(bus.overflow), 0);
    check("underflow cleared", int'(bus.underflow), 0);
`endif
    step(1, 0, 0);
    check_outs("post-reset read", 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i + 1);
      check($sformatf("refill%0d wr_ready", i), int'(bus.wr_ready), i < 3 ? 1 : 0);
    end
    step(1, 0, 0);
    check_outs("refill head", 1, 1, 1);
    step(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Single-clock, parameterised first-in/first-out buffer that decouples a producer from a consumer inside one clock domain.
- Write side: request/ready handshake.
- Read side: request in, then a registered data/valid pair one cycle later.
- Storage is a 1-write/1-read register array addressed by wrapping pointers.

Parameters:
- FIFO_DEPTH, default 4: number of entries; must be a power of two and at least 2.
- DATA_WIDTH, default 4: width of one entry in bits.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- rd_en  input  1  read request; sampled at the rising edge of clk.
- wr_en  input  1  write request; sampled at the rising edge of clk.
- wr_data  input  DATA_WIDTH  write data; captured when a write is accepted.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_val  output  1  registered; high for exactly one cycle after each accepted read.
- wr_ready  output  1  combinational; high when the FIFO is not full.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset effects: wr_ptr=0, rd_ptr=0, count=0, rd_val=0, rd_data=0, so wr_ready=1. Memory contents are not cleared.
- Reset mid-operation: reset overrides any same-edge rd_en/wr_en; all stored entries are discarded.
- Internal state:
  - count: width $clog2(FIFO_DEPTH)+1.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - wr_ready = !full.
- Write accept: wr_en && !full at a clock edge.
  - mem[wr_ptr] <= wr_data; wr_ptr increments modulo FIFO_DEPTH (natural wrap).
- Write while full: ignored; no state change and no error response.
- Read accept: rd_en && !empty at a clock edge.
  - rd_data <= mem[rd_ptr]; rd_ptr increments modulo FIFO_DEPTH; rd_val <= 1.
  - Latency is 1 cycle: data and valid appear after the edge that accepted the request.
- Read not accepted (rd_en low, or empty): rd_val <= 0; rd_data holds its last value.
- Simultaneous accepted read and write: both take effect and count is unchanged.
- Empty with rd_en and wr_en together: only the write is accepted. There is no fall-through, and rd_val stays 0 for that edge.
- Full with rd_en and wr_en together: only the read is accepted, because wr_ready is low; the write is dropped.
- Ordering: strict FIFO order is preserved across pointer wrap-around.
- Pointer width: $clog2(FIFO_DEPTH).
- Count update: count +1 on write-only, -1 on read-only.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - overflow: 1 bit, sticky; set at the edge where wr_en && full.
  - underflow: 1 bit, sticky; set at the edge where rd_en && empty.
  - Both are cleared only by reset.
- When undefined, these ports and their logic do not exist. Core behaviour is identical either way.

Decomposition:
- Package sync_fifo_pkg:
  - default-parameter localparams: DEF_FIFO_DEPTH=4, DEF_DATA_WIDTH=4.
  - function computing pointer/count widths.
- One natural sub-module: sync_fifo_mem.
  - Parameterised FIFO_DEPTH x DATA_WIDTH register array.
  - Write port: we, waddr, wdata. Asynchronous read port: raddr, rdata.
  - Pointers, count, flags and output registers live in the top module.

Test Plan:
- Reset, then rd_en=1 for one cycle while empty -> rd_val=0; rd_data=0; wr_ready=1.
- Write 6, 8, 4, 10 on consecutive cycles -> wr_ready is 1 after the first three writes and 0 after the fourth (count=4).
- Write 12 while full -> not stored; wr_ready stays 0. With FIFO_ERR_FLAGS_EN, overflow=1.
- Five consecutive reads after the above:
  - The first four read cycles return rd_val=1 with rd_data=6, 8, 4, 10 in order; wr_ready returns to 1 after the first read.
  - The fifth returns rd_val=0 with rd_data held at 10. With FIFO_ERR_FLAGS_EN, underflow=1.
- Wrap and simultaneous access:
  - Write 1, 2, 3; read one; then write 5 and read together for 4 cycles.
  - Reads return 1, 2, 3, 5, ... in order; count stays constant during the simultaneous phase.
  - Pointers wrap past FIFO_DEPTH-1 without losing or duplicating data.
- Reset mid-operation: with 3 entries stored, assert reset for one edge while rd_en=1 -> rd_val=0, rd_data=0, wr_ready=1; a following read returns rd_val=0 (empty).
